// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared constants and helpers for the ALU arbiter
//
// Purpose: ALU width constant, {funct7[5], funct3} field codes, buffer state
// type and a field legality check that decode logic can reuse.
// Ports: none (package).

package alu_arbiter_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] AND  = 4'b0111;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    function automatic logic field_is_legal(input logic [3:0] field);
        case (field)
            ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit integer ALU
//
// Purpose: computes the selected operation on two operands.
// Ports:
//   op1, op2 : operands
//   field    : {funct7[5], funct3} operation select
//   result   : operation result, forced to 0 for illegal codes
//   err      : high when field is not a legal code

module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      field,
    output logic [XLEN-1:0] result,
    output logic            err
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        err    = !field_is_legal(field);
        case (field)
            ADD:  result = op1 + op2;
            SUB:  result = op1 - op2;
            AND:  result = op1 & op2;
            OR:   result = op1 | op2;
            XOR:  result = op1 ^ op2;
            SLL:  result = op1 << shamt;
            SRL:  result = op1 >> shamt;
            SRA:  result = $signed(op1) >>> shamt;
            SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            SLTU: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Purpose: arbitrates two valid/ready requesters onto a single ALU and holds
// the result in a one-entry buffer until the owning requester consumes it.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   req{0,1}_valid / req{0,1}_ready    : request handshake
//   req{0,1}_op1, _op2, _field         : operands and operation select
//   resp{0,1}_valid / resp{0,1}_ready  : response handshake
//   resp{0,1}_result, resp{0,1}_err    : buffered result and illegal-code flag

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [3:0]      req0_field,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_result,
    output logic            resp0_err,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [3:0]      req1_field,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_result,
    output logic            resp1_err
);

    buf_state_t      state;
    logic            owner;
    logic            last_grant;
    logic [XLEN-1:0] buf_result;
    logic            buf_err;

    logic            grant;
    logic            drain;
    logic            can_accept;
    logic            accept;

    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [3:0]      alu_field;
    logic [XLEN-1:0] alu_result;
    logic            alu_err;

    // Lone requester wins outright; on a tie the one that did not win last.
    // With nobody valid the grant idles at 0, which is harmless.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign resp0_valid = (state == FULL) && !owner;
    assign resp1_valid = (state == FULL) &&  owner;

    // Draining and refilling in the same cycle keeps one op per cycle.
    assign drain      = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
    assign can_accept = (state == EMPTY) || drain;

    assign req0_ready = can_accept && !grant;
    assign req1_ready = can_accept &&  grant;

    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign alu_op1   = grant ? req1_op1   : req0_op1;
    assign alu_op2   = grant ? req1_op2   : req0_op2;
    assign alu_field = grant ? req1_field : req0_field;

    alu_arbiter_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op1    (alu_op1),
        .op2    (alu_op2),
        .field  (alu_field),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            buf_result <= '0;
            buf_err    <= 1'b0;
        end else if (accept) begin
            state      <= FULL;
            owner      <= grant;
            last_grant <= grant;
            buf_result <= alu_result;
            buf_err    <= alu_err;
        end else if (drain) begin
            state      <= EMPTY;
        end
    end

    // Both ports mirror the buffer; each consumer qualifies with its own valid.
    assign resp0_result = buf_result;
    assign resp1_result = buf_result;
    assign resp0_err    = buf_err;
    assign resp1_err    = buf_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_op1, req0_op2;
    logic [3:0]  req0_field;
    logic        resp0_valid, resp0_ready;
    logic [31:0] resp0_result;
    logic        resp0_err;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_op1, req1_op2;
    logic [3:0]  req1_field;
    logic        resp1_valid, resp1_ready;
    logic [31:0] resp1_result;
    logic        resp1_err;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_arbiter #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op1     (req0_op1),
        .req0_op2     (req0_op2),
        .req0_field   (req0_field),
        .resp0_valid  (resp0_valid),
        .resp0_ready  (resp0_ready),
        .resp0_result (resp0_result),
        .resp0_err    (resp0_err),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op1     (req1_op1),
        .req1_op2     (req1_op2),
        .req1_field   (req1_field),
        .resp1_valid  (resp1_valid),
        .resp1_ready  (resp1_ready),
        .resp1_result (resp1_result),
        .resp1_err    (resp1_err)
    );

    always #5 clk = ~clk;

    // Directed vectors for requester 0, issued back to back.
    logic [3:0]  v_field [0:10] = '{4'b0001, 4'b0011, 4'b0111, 4'b0110, 4'b0100, 4'b0101,
                                    4'b0010, 4'b1000, 4'b0000, 4'b1111, 4'b1101};
    logic [31:0] v_op1 [0:10] = '{32'h1, 32'h1, 32'hF0F0F0F0, 32'hF0F00000, 32'hFFFF0000,
                                  32'h80000000, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h5, 32'h70000000};
    logic [31:0] v_op2 [0:10] = '{32'h23, 32'hFFFFFFFF, 32'h0FF00FF0, 32'h00000F0F, 32'h0F0F0F0F,
                                  32'h1F, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h5, 32'h24};
    logic [31:0] v_exp [0:10] = '{32'h8, 32'h1, 32'h00F000F0, 32'hF0F00F0F, 32'hF0F00F0F,
                                  32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h07000000};
    logic        v_err [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic idle();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_field = '0; resp0_ready = 1'b0;
        req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_field = '0; resp1_ready = 1'b0;
        #12;
        n_cmp++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp0_valid: got %b want 0", resp0_valid); end
        n_cmp++; if (resp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp1_valid: got %b want 0", resp1_valid); end
        n_cmp++; if (resp0_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", resp0_result); end
        n_cmp++; if (resp0_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", resp0_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        req0_valid = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd7; req0_field = 4'b0000; resp0_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_req0_ready: got %b want 1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL add_req1_ready: got %b want 0", req1_ready); end
        n_cmp++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b want 0", resp0_valid); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL add_resp0_valid: got %b want 1", resp0_valid); end
        n_cmp++; if (resp0_result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h want c", resp0_result); end
        n_cmp++; if (resp0_err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b want 0", resp0_err); end
        n_cmp++; if (resp1_valid !== 1'b0) begin n_fail++; $display("FAIL add_resp1_valid: got %b want 0", resp1_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained: got %b want 0", resp0_valid); end
    endtask

    task automatic test_round_robin();
        logic        e0, e1;
        logic [31:0] er;
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd3; req0_field = 4'b1000;
        req1_valid = 1'b1; req1_op1 = 32'hFFFFFFFF; req1_op2 = 32'd1; req1_field = 4'b0010;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            e0 = ((k % 2) == 0);
            e1 = ((k % 2) == 1);
            n_cmp++; if (req0_ready !== e0) begin n_fail++; $display("FAIL rr_req0_ready[%0d]: got %b want %b", k, req0_ready, e0); end
            n_cmp++; if (req1_ready !== e1) begin n_fail++; $display("FAIL rr_req1_ready[%0d]: got %b want %b", k, req1_ready, e1); end
            if (k > 0) begin
                // previous cycle's grant is the opposite of this cycle's
                er = e1 ? 32'd7 : 32'd1;
                n_cmp++; if (resp0_valid !== e1) begin n_fail++; $display("FAIL rr_resp0_valid[%0d]: got %b want %b", k, resp0_valid, e1); end
                n_cmp++; if (resp1_valid !== e0) begin n_fail++; $display("FAIL rr_resp1_valid[%0d]: got %b want %b", k, resp1_valid, e0); end
                n_cmp++; if (resp0_result !== er) begin n_fail++; $display("FAIL rr_result[%0d]: got %h want %h", k, resp0_result, er); end
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_cmp++; if (resp1_valid !== 1'b1) begin n_fail++; $display("FAIL rr_last_valid: got %b want 1", resp1_valid); end
        n_cmp++; if (resp1_result !== 32'd1) begin n_fail++; $display("FAIL rr_last_result: got %h want 1", resp1_result); end
    endtask

    task automatic test_backpressure();
        idle();
        idle();
        @(negedge clk);
        req1_valid = 1'b1; req1_op1 = 32'h80000000; req1_op2 = 32'd4; req1_field = 4'b1101;
        resp1_ready = 1'b0;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_req1_accept: got %b want 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd2; req0_field = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_cmp++; if (resp1_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, resp1_valid); end
            n_cmp++; if (resp1_result !== 32'hF8000000) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h want f8000000", i, resp1_result); end
            n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req0_stall[%0d]: got %b want 0", i, req0_ready); end
            n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req1_stall[%0d]: got %b want 0", i, req1_ready); end
        end
        @(negedge clk);
        resp1_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_accept: got %b want 1", req0_ready); end
        n_cmp++; if (resp1_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b want 1", resp1_valid); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", resp0_valid); end
        n_cmp++; if (resp0_result !== 32'd3) begin n_fail++; $display("FAIL bp_next_result: got %h want 3", resp0_result); end
        n_cmp++; if (resp1_valid !== 1'b0) begin n_fail++; $display("FAIL bp_resp1_cleared: got %b want 0", resp1_valid); end
    endtask

    task automatic test_illegal();
        idle();
        @(negedge clk);
        req0_valid = 1'b1; req0_op1 = 32'd3; req0_op2 = 32'd4; req0_field = 4'b1001;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL ill_accept: got %b want 1", req0_ready); end
        @(negedge clk);
        req0_field = 4'b0000;
        #1;
        n_cmp++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL ill_valid: got %b want 1", resp0_valid); end
        n_cmp++; if (resp0_result !== 32'h0) begin n_fail++; $display("FAIL ill_result: got %h want 0", resp0_result); end
        n_cmp++; if (resp0_err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", resp0_err); end
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL ill_no_stall: got %b want 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (resp0_result !== 32'd7) begin n_fail++; $display("FAIL ill_next_result: got %h want 7", resp0_result); end
        n_cmp++; if (resp0_err !== 1'b0) begin n_fail++; $display("FAIL ill_next_err: got %b want 0", resp0_err); end
    endtask

    task automatic test_vectors();
        idle();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_op1 = v_op1[i]; req0_op2 = v_op2[i]; req0_field = v_field[i];
            #1;
            n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL vec_ready[%0d]: got %b want 1", i, req0_ready); end
            if (i > 0) begin
                n_cmp++; if (resp0_result !== v_exp[i-1]) begin n_fail++; $display("FAIL vec_result[%0d]: got %h want %h", i-1, resp0_result, v_exp[i-1]); end
                n_cmp++; if (resp0_err !== v_err[i-1]) begin n_fail++; $display("FAIL vec_err[%0d]: got %b want %b", i-1, resp0_err, v_err[i-1]); end
            end
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (resp0_result !== v_exp[10]) begin n_fail++; $display("FAIL vec_result[10]: got %h want %h", resp0_result, v_exp[10]); end
        n_cmp++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL vec_last_valid: got %b want 1", resp0_valid); end
    endtask

    task automatic test_async_reset();
        idle();
        @(negedge clk);
        req0_valid = 1'b1; req0_op1 = 32'd2; req0_op2 = 32'd2; req0_field = 4'b0000;
        resp0_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b want 1", resp0_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_drop: got %b want 0", resp0_valid); end
        n_cmp++; if (resp0_result !== 32'h0) begin n_fail++; $display("FAIL ar_result_clear: got %h want 0", resp0_result); end
        @(negedge clk);
        rst_n = 1'b1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op1 = 32'd9; req0_op2 = 32'd1; req0_field = 4'b1000;
        req1_valid = 1'b1; req1_op1 = 32'd1; req1_op2 = 32'd1; req1_field = 4'b0000;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL ar_first_req0: got %b want 1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL ar_first_req1: got %b want 0", req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_cmp++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL ar_post_valid: got %b want 1", resp0_valid); end
        n_cmp++; if (resp0_result !== 32'd8) begin n_fail++; $display("FAIL ar_post_result: got %h want 8", resp0_result); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_vectors();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
